// File: rtl/display_pkg.sv
// Shared types and constants for the signed-value seven-segment display path.
// Holds the converter FSM encoding, BCD digit type and segment patterns.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ABS   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } conv_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int BCD_ACC_DIGITS = 5;

  // Segment order {g,f,e,d,c,b,a}, active high
  localparam logic [6:0] SEG_0     = 7'h3f;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5b;
  localparam logic [6:0] SEG_3     = 7'h4f;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6d;
  localparam logic [6:0] SEG_6     = 7'h7d;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7f;
  localparam logic [6:0] SEG_9     = 7'h6f;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_dabble_step.sv
// One nibble of the shift-add-3 correction.
// Digits of 5 or more get +3 so the next left shift carries correctly.
module bcd_dabble_step
  import display_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/signed_bcd_converter.sv
// Signed sample to packed BCD magnitude with sign, saturation and level.
// Iterative double-dabble: one binary bit per clock after an ABS cycle.
module signed_bcd_converter
  import display_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIGITS     = 4,
  parameter int LEVEL_STEP = 30
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [WIDTH-1:0]      i_data,
  output logic                  o_done,
  output logic                  o_sign,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_overflow,
  output logic [2:0]            o_level
);

  localparam int ACC_W   = 4 * BCD_ACC_DIGITS;
  localparam int MAX_MAG = (10 ** DIGITS) - 1;

  conv_state_e state_q, state_d;

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] bin_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_adj;
  logic [ACC_W-1:0] acc_nxt;
  logic [4:0]       cnt_q;
  logic             sign_q;
  logic             ovf_q;
  logic [2:0]       lvl_q;
  logic [WIDTH:0]   ext;
  logic [WIDTH:0]   mag;
  logic             ovf_c;
  logic [2:0]       lvl_c;
  logic             last;
  logic             unused_ok;

  // Extra bit keeps -2^(WIDTH-1) exact after negation
  assign ext = {data_q[WIDTH-1], data_q};
  assign mag = data_q[WIDTH-1] ? (~ext + 1'b1) : ext;

  assign ovf_c = 32'(mag) > 32'(MAX_MAG);
  assign last  = (cnt_q == 5'(WIDTH - 1));

  always_comb begin
    lvl_c = 3'd7;
    for (int k = 1; k <= 7; k++) begin
      if (32'(mag) > 32'(k * LEVEL_STEP)) lvl_c = 3'(7 - k);
    end
  end

  for (genvar g = 0; g < BCD_ACC_DIGITS; g++) begin : g_dabble
    bcd_dabble_step u_step (
      .d (acc_q[4*g +: 4]),
      .q (acc_adj[4*g +: 4])
    );
  end

  assign acc_nxt   = {acc_adj[ACC_W-2:0], bin_q[WIDTH-1]};
  assign unused_ok = ^{acc_adj[ACC_W-1], acc_nxt};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_valid) state_d = ABS;
      ABS:     state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == IDLE);
    o_done  = (state_q == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q     <= '0;
      bin_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      lvl_q      <= 3'd7;
      o_sign     <= 1'b0;
      o_bcd      <= '0;
      o_overflow <= 1'b0;
      o_level    <= 3'd7;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_valid) data_q <= i_data;
        end
        ABS: begin
          sign_q <= data_q[WIDTH-1];
          ovf_q  <= ovf_c;
          lvl_q  <= lvl_c;
          bin_q  <= mag[WIDTH-1:0];
          acc_q  <= '0;
          cnt_q  <= '0;
        end
        SHIFT: begin
          acc_q <= acc_nxt;
          bin_q <= {bin_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
          if (last) begin
            o_sign     <= sign_q;
            o_overflow <= ovf_q;
            o_level    <= lvl_q;
            o_bcd      <= ovf_q ? {DIGITS{4'h9}}
                                : acc_nxt[4*DIGITS-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Directed bench for signed_bcd_converter at default parameters.
// Scenario tasks compare outputs against hand-computed values.
module tb_signed_bcd_converter;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] i_data = '0;
  logic        o_done;
  logic        o_sign;
  logic [15:0] o_bcd;
  logic        o_overflow;
  logic [2:0]  o_level;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  signed_bcd_converter #(
    .WIDTH(16), .DIGITS(4), .LEVEL_STEP(30)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .o_done     (o_done),
    .o_sign     (o_sign),
    .o_bcd      (o_bcd),
    .o_overflow (o_overflow),
    .o_level    (o_level)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int a;
    a = (v < 0) ? -v : v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(a % 10);
      a = a / 10;
    end
    return r;
  endfunction

  // Drives one accept and waits for o_done; lat = edges after accept
  task automatic run(input logic [15:0] d, output int lat,
                     output logic done_after);
    @(negedge i_clk);
    i_data  = d;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge i_clk);
      #1;
      if (o_done) begin
        lat = n;
        break;
      end
    end
    @(posedge i_clk);
    #1 done_after = o_done;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #12;
    checks++;
    if ({o_done, o_sign, o_bcd, o_overflow, o_level, o_ready}
        !== {1'b0, 1'b0, 16'h0, 1'b0, 3'd7, 1'b1}) begin
      errors++;
      $display("FAIL reset: got done=%b sign=%b bcd=%h ovf=%b lvl=%0d rdy=%b exp 0 0 0000 0 7 1",
               o_done, o_sign, o_bcd, o_overflow, o_level, o_ready);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b exp 1", o_ready);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic [15:0] bcd;
    logic        sign;
    logic        ovf;
    logic [2:0]  lvl;
  } vec_t;

  task automatic test_conversions();
    vec_t v[12];
    int lat;
    logic da;
    v[0]  = '{16'd1234,  16'h1234, 1'b0, 1'b0, 3'd0};
    v[1]  = '{-16'sd45,  16'h0045, 1'b1, 1'b0, 3'd6};
    v[2]  = '{16'h8000,  16'h9999, 1'b1, 1'b1, 3'd0};
    v[3]  = '{16'd0,     16'h0000, 1'b0, 1'b0, 3'd7};
    v[4]  = '{16'd30,    16'h0030, 1'b0, 1'b0, 3'd7};
    v[5]  = '{16'd31,    16'h0031, 1'b0, 1'b0, 3'd6};
    v[6]  = '{16'd211,   16'h0211, 1'b0, 1'b0, 3'd0};
    v[7]  = '{16'd210,   16'h0210, 1'b0, 1'b0, 3'd1};
    v[8]  = '{16'd9999,  16'h9999, 1'b0, 1'b0, 3'd0};
    v[9]  = '{16'd10000, 16'h9999, 1'b0, 1'b1, 3'd0};
    v[10] = '{16'hffff,  16'h0001, 1'b1, 1'b0, 3'd7};
    v[11] = '{16'd32767, 16'h9999, 1'b0, 1'b1, 3'd0};
    foreach (v[i]) begin
      run(v[i].d, lat, da);
      checks++;
      if (lat != 17) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d exp 17", i, lat);
      end
      checks++;
      if ({o_bcd, o_sign, o_overflow, o_level}
          !== {v[i].bcd, v[i].sign, v[i].ovf, v[i].lvl}) begin
        errors++;
        $display("FAIL conv[%0d] d=%h: got bcd=%h sign=%b ovf=%b lvl=%0d exp bcd=%h sign=%b ovf=%b lvl=%0d",
                 i, v[i].d, o_bcd, o_sign, o_overflow, o_level,
                 v[i].bcd, v[i].sign, v[i].ovf, v[i].lvl);
      end
      checks++;
      if (da !== 1'b0) begin
        errors++;
        $display("FAIL done_width[%0d]: got %b exp 0", i, da);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int acc_dat[$];
    int res_idx = 0;
    int stab_err = 0;
    logic seen = 1'b0;
    logic rdy;
    logic [15:0] held = '0;
    int dv;
    @(negedge i_clk);
    i_valid = 1'b1;
    for (int c = 0; c < 66; c++) begin
      dv = c * 37 + 5;
      i_data = 16'(dv);
      rdy = o_ready;
      @(posedge i_clk);
      #1;
      if (rdy) begin
        acc_cyc.push_back(c);
        acc_dat.push_back(dv);
      end
      if (o_done) begin
        checks++;
        if (res_idx >= acc_dat.size() ||
            o_bcd !== to_bcd(acc_dat[res_idx])) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got %h exp %h", res_idx, o_bcd,
                   (res_idx < acc_dat.size()) ? to_bcd(acc_dat[res_idx]) : 16'h0);
        end
        res_idx++;
        held = o_bcd;
        seen = 1'b1;
      end else if (seen && o_bcd !== held) begin
        stab_err++;
      end
    end
    i_valid = 1'b0;
    checks++;
    if (acc_cyc.size() != 4) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d exp 4", acc_cyc.size());
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 19) begin
        errors++;
        $display("FAIL b2b_spacing[%0d]: got %0d exp 19", i,
                 acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    checks++;
    if (stab_err != 0) begin
      errors++;
      $display("FAIL b2b_stable: got %0d changes exp 0", stab_err);
    end
    repeat (25) @(posedge i_clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    logic da;
    run(-16'sd45, lat, da);
    @(negedge i_clk);
    i_data  = 16'd5000;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    repeat (8) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_done, o_sign, o_bcd, o_overflow, o_level}
        !== {1'b0, 1'b0, 16'h0, 1'b0, 3'd7}) begin
      errors++;
      $display("FAIL mid_reset: got done=%b sign=%b bcd=%h ovf=%b lvl=%0d exp 0 0 0000 0 7",
               o_done, o_sign, o_bcd, o_overflow, o_level);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready: got %b exp 1", o_ready);
    end
    run(16'd777, lat, da);
    checks++;
    if (lat != 17 || o_bcd !== 16'h0777 || o_sign !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_conv: got lat=%0d bcd=%h sign=%b exp 17 0777 0",
               lat, o_bcd, o_sign);
    end
  endtask

  initial begin
    test_reset();
    test_conversions();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
